// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target responder and the master handler.
package i2c_pkg;

   // Default 7-bit device address the target answers to
   localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h50;

   // Command codes understood by the master handler
   localparam logic [7:0] CMD_WRITE      = 8'h04;
   localparam logic [7:0] CMD_READ       = 8'h05;
   localparam logic [7:0] CMD_WRITE_READ = 8'h06;

   // Target state encoding
   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_DEV_ADDR = 4'd1;
   localparam logic [3:0] ST_ACK_DEV  = 4'd2;
   localparam logic [3:0] ST_REG_HI   = 4'd3;
   localparam logic [3:0] ST_ACK_HI   = 4'd4;
   localparam logic [3:0] ST_REG_LO   = 4'd5;
   localparam logic [3:0] ST_ACK_LO   = 4'd6;
   localparam logic [3:0] ST_WR_DATA  = 4'd7;
   localparam logic [3:0] ST_ACK_WR   = 4'd8;
   localparam logic [3:0] ST_RD_LOAD  = 4'd9;
   localparam logic [3:0] ST_RD_DATA  = 4'd10;
   localparam logic [3:0] ST_RD_ACK   = 4'd11;
   localparam logic [3:0] ST_IGNORE   = 4'd12;

   typedef enum logic [3:0] {
      S_IDLE     = ST_IDLE,
      S_DEV_ADDR = ST_DEV_ADDR,
      S_ACK_DEV  = ST_ACK_DEV,
      S_REG_HI   = ST_REG_HI,
      S_ACK_HI   = ST_ACK_HI,
      S_REG_LO   = ST_REG_LO,
      S_ACK_LO   = ST_ACK_LO,
      S_WR_DATA  = ST_WR_DATA,
      S_ACK_WR   = ST_ACK_WR,
      S_RD_LOAD  = ST_RD_LOAD,
      S_RD_DATA  = ST_RD_DATA,
      S_RD_ACK   = ST_RD_ACK,
      S_IGNORE   = ST_IGNORE
   } target_state_t;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Brings SCL/SDA into the clk domain and flags bus edges, START and STOP.
module i2c_bus_monitor (
   input  logic clk,
   input  logic scl,
   input  logic sda,
   output logic scl_s,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [1:0] scl_sync;
   logic [1:0] sda_sync;
   logic       scl_prev;
   logic       sda_prev;

   // Free-running 2-FF synchronisers plus previous-value registers; left unreset so a reset
   // in the middle of a transfer cannot fabricate an edge from a stale reset value
   always_ff @(posedge clk) begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_prev <= scl_sync[1];
      sda_prev <= sda_sync[1];
   end

   assign scl_s     = scl_sync[1];
   assign sda_s     = sda_sync[1];
   assign scl_rise  = scl_s & ~scl_prev;
   assign scl_fall  = ~scl_s & scl_prev;
   assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
   assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target with 16-bit register pointer, byte memory, host port and write strobe.
module i2c_target_responder
   import i2c_pkg::*;
#(
   parameter int         MEM_DEPTH    = 256,
   parameter logic [6:0] DEV_ADDR_RST = DEV_ADDR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i2c_scl,
   inout  wire         i2c_sda,
   input  logic        dev_addr_wr,
   input  logic [6:0]  dev_addr_in,
   input  logic        host_we,
   input  logic [15:0] host_addr,
   input  logic [7:0]  host_wdata,
   output logic [7:0]  host_rdata,
   output logic        wr_valid,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        busy
);

   localparam int AW = $clog2(MEM_DEPTH);

   logic          scl_s;
   logic          sda_s;
   logic          scl_rise;
   logic          scl_fall;
   logic          start_det;
   logic          stop_det;

   target_state_t state;
   target_state_t ack_next;
   logic [3:0]    bit_cnt;
   logic [7:0]    shreg;
   logic [15:0]   ptr;
   logic          rw_bit;
   logic          sda_oe;
   logic [6:0]    dev_addr_reg;
   logic [6:0]    dev_addr_eff;
   logic [7:0]    rx_byte;
   logic [7:0]    rd_byte;
   logic          i2c_we;
   logic [AW-1:0] ptr_idx;
   logic [AW-1:0] host_idx;
   logic [7:0]    mem [MEM_DEPTH];

   i2c_bus_monitor u_mon (
      .clk       (clk),
      .scl       (i2c_scl),
      .sda       (i2c_sda),
      .scl_s     (scl_s),
      .sda_s     (sda_s),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

   assign ptr_idx      = AW'({1'b0, ptr} % 17'(MEM_DEPTH));
   assign host_idx     = AW'({1'b0, host_addr} % 17'(MEM_DEPTH));
   assign rx_byte      = {shreg[6:0], sda_s};
   assign rd_byte      = mem[ptr_idx];
   assign dev_addr_eff = dev_addr_wr ? dev_addr_in : dev_addr_reg;
   assign i2c_we       = (state == S_WR_DATA) && scl_rise && (bit_cnt == 4'd7);

   // Where each ACK slot hands over once the acknowledge bit has been clocked out
   always_comb begin
      ack_next = S_WR_DATA;
      case (state)
         S_ACK_DEV: ack_next = rw_bit ? S_RD_LOAD : S_REG_HI;
         S_ACK_HI:  ack_next = S_REG_LO;
         default:   ack_next = S_WR_DATA;
      endcase
   end

   // Device address register, reloadable from the host at any time
   always_ff @(posedge clk) begin
      if (rst) dev_addr_reg <= DEV_ADDR_RST;
      else if (dev_addr_wr) dev_addr_reg <= dev_addr_in;
   end

   // Protocol FSM: receive shifting on SCL rise, SDA drive changes on SCL fall
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         bit_cnt  <= 4'd0;
         shreg    <= 8'd0;
         ptr      <= 16'd0;
         rw_bit   <= 1'b0;
         sda_oe   <= 1'b0;
         busy     <= 1'b0;
         wr_valid <= 1'b0;
         wr_addr  <= 16'd0;
         wr_data  <= 8'd0;
      end else begin
         wr_valid <= 1'b0;
         if (start_det) begin
            state   <= S_DEV_ADDR;
            bit_cnt <= 4'd0;
            sda_oe  <= 1'b0;
            busy    <= 1'b1;
         end else if (stop_det) begin
            state  <= S_IDLE;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
         end else begin
            case (state)
               S_DEV_ADDR, S_REG_HI, S_REG_LO, S_WR_DATA: begin
                  if (scl_rise) begin
                     shreg   <= rx_byte;
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd7) begin
                        case (state)
                           S_DEV_ADDR: begin
                              if (rx_byte[7:1] == dev_addr_eff) begin
                                 rw_bit <= rx_byte[0];
                                 state  <= S_ACK_DEV;
                              end else begin
                                 state <= S_IGNORE;
                              end
                           end
                           S_REG_HI: begin
                              ptr[15:8] <= rx_byte;
                              state     <= S_ACK_HI;
                           end
                           S_REG_LO: begin
                              ptr[7:0] <= rx_byte;
                              state    <= S_ACK_LO;
                           end
                           default: begin
                              wr_valid <= 1'b1;
                              wr_addr  <= ptr;
                              wr_data  <= rx_byte;
                              ptr      <= ptr + 16'd1;
                              state    <= S_ACK_WR;
                           end
                        endcase
                     end
                  end
               end
               S_ACK_DEV, S_ACK_HI, S_ACK_LO, S_ACK_WR: begin
                  if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        sda_oe  <= 1'b1;
                        bit_cnt <= 4'd9;
                     end else begin
                        sda_oe  <= 1'b0;
                        bit_cnt <= 4'd0;
                        state   <= ack_next;
                     end
                  end
               end
               S_RD_LOAD: begin
                  // Wait for SCL low so the first data bit never moves while SCL is high
                  if (!scl_s) begin
                     shreg   <= rd_byte;
                     sda_oe  <= ~rd_byte[7];
                     bit_cnt <= 4'd0;
                     state   <= S_RD_DATA;
                  end
               end
               S_RD_DATA: begin
                  if (scl_fall) begin
                     if (bit_cnt == 4'd7) begin
                        sda_oe  <= 1'b0;
                        ptr     <= ptr + 16'd1;
                        bit_cnt <= 4'd0;
                        state   <= S_RD_ACK;
                     end else begin
                        sda_oe  <= ~shreg[6];
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end
               S_RD_ACK: begin
                  if (scl_rise) state <= sda_s ? S_IGNORE : S_RD_LOAD;
               end
               default: sda_oe <= 1'b0;
            endcase
         end
      end
   end

   // Byte memory; the I2C write is applied last so it wins a same-index collision
   always_ff @(posedge clk) begin
      if (host_we) mem[host_idx] <= host_wdata;
      if (i2c_we) mem[ptr_idx] <= rx_byte;
   end

   // Registered host readback
   always_ff @(posedge clk) begin
      if (rst) host_rdata <= 8'd0;
      else host_rdata <= mem[host_idx];
   end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Randomised bench for i2c_target_responder with a bit-banged I2C master and a byte-level model.
module tb_i2c_target_responder;

   localparam int Q = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        scl = 1'b1;
   logic        m_oe = 1'b0;
   logic        dev_addr_wr = 1'b0;
   logic [6:0]  dev_addr_in = 7'h50;
   logic        host_we = 1'b0;
   logic [15:0] host_addr = 16'd0;
   logic [7:0]  host_wdata = 8'd0;
   logic [7:0]  host_rdata;
   logic        wr_valid;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic        busy;
   wire         sda;

   pullup (sda);
   assign sda = m_oe ? 1'b0 : 1'bz;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  model_mem [256];
   logic [15:0] model_ptr = 16'd0;
   logic [23:0] wr_log [128];
   int          wr_cnt = 0;
   int          tgt_low_cnt = 0;

   i2c_target_responder dut (
      .clk         (clk),
      .rst         (rst),
      .i2c_scl     (scl),
      .i2c_sda     (sda),
      .dev_addr_wr (dev_addr_wr),
      .dev_addr_in (dev_addr_in),
      .host_we     (host_we),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_rdata  (host_rdata),
      .wr_valid    (wr_valid),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Log every write notification and count cycles where the target holds SDA low
   always @(negedge clk) begin
      if (wr_valid === 1'b1 && wr_cnt < 128) begin
         wr_log[wr_cnt] = {wr_addr, wr_data};
         wr_cnt = wr_cnt + 1;
      end
      if (m_oe == 1'b0 && sda === 1'b0) tgt_low_cnt = tgt_low_cnt + 1;
   end

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic host_write(input logic [15:0] a, input logic [7:0] d);
      host_addr = a; host_wdata = d; host_we = 1'b1;
      wait_clk(1);
      host_we = 1'b0;
   endtask

   task automatic host_read(input logic [15:0] a, output logic [7:0] d);
      host_addr = a;
      wait_clk(1);
      d = host_rdata;
   endtask

   task automatic i2c_start();
      m_oe = 1'b0; wait_clk(Q);
      scl = 1'b1;  wait_clk(Q);
      m_oe = 1'b1; wait_clk(Q);
      scl = 1'b0;  wait_clk(Q);
   endtask

   task automatic i2c_stop();
      m_oe = 1'b1; wait_clk(Q);
      scl = 1'b1;  wait_clk(Q);
      m_oe = 1'b0; wait_clk(2 * Q);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit collide, input logic [15:0] caddr,
                            input logic [7:0] cdata, output bit ack);
      for (int i = 7; i >= 0; i--) begin
         m_oe = ~b[i]; wait_clk(Q);
         scl = 1'b1;
         if (collide && i == 0) begin
            wait_clk(2);
            host_addr = caddr; host_wdata = cdata; host_we = 1'b1;
            wait_clk(1);
            host_we = 1'b0;
            wait_clk(2 * Q - 3);
         end else begin
            wait_clk(2 * Q);
         end
         scl = 1'b0; wait_clk(Q);
      end
      m_oe = 1'b0; wait_clk(Q);
      scl = 1'b1;  wait_clk(Q);
      ack = (sda === 1'b0);
      wait_clk(Q);
      scl = 1'b0;  wait_clk(Q);
   endtask

   task automatic recv_byte(input bit nack, output logic [7:0] b);
      m_oe = 1'b0;
      b = 8'd0;
      for (int i = 0; i < 8; i++) begin
         wait_clk(Q);
         scl = 1'b1; wait_clk(Q);
         b = {b[6:0], (sda === 1'b1)};
         wait_clk(Q);
         scl = 1'b0;
      end
      wait_clk(Q);
      m_oe = ~nack; wait_clk(Q);
      scl = 1'b1;   wait_clk(2 * Q);
      scl = 1'b0;   wait_clk(Q);
      m_oe = 1'b0;
   endtask

   task automatic i2c_write_txn(input logic [15:0] addr, input logic [7:0] data [8], input int n,
                                output bit all_ack, output bit busy_mid);
      bit ack;
      logic [15:0] p;
      p = addr;
      i2c_start();
      busy_mid = busy;
      send_byte(8'hA0, 1'b0, 16'd0, 8'd0, ack);      all_ack = ack;
      send_byte(addr[15:8], 1'b0, 16'd0, 8'd0, ack); all_ack &= ack;
      send_byte(addr[7:0], 1'b0, 16'd0, 8'd0, ack);  all_ack &= ack;
      for (int i = 0; i < n; i++) begin
         send_byte(data[i], 1'b0, 16'd0, 8'd0, ack);
         all_ack &= ack;
         model_mem[p[7:0]] = data[i];
         p = p + 16'd1;
      end
      i2c_stop();
      model_ptr = p;
   endtask

   task automatic i2c_read_txn(input logic [15:0] addr, input int n, output logic [7:0] rd [8],
                               output bit all_ack, output bit released);
      bit ack;
      i2c_start();
      send_byte(8'hA0, 1'b0, 16'd0, 8'd0, ack);      all_ack = ack;
      send_byte(addr[15:8], 1'b0, 16'd0, 8'd0, ack); all_ack &= ack;
      send_byte(addr[7:0], 1'b0, 16'd0, 8'd0, ack);  all_ack &= ack;
      i2c_start();
      send_byte(8'hA1, 1'b0, 16'd0, 8'd0, ack);      all_ack &= ack;
      for (int i = 0; i < n; i++) recv_byte(i == n - 1, rd[i]);
      wait_clk(2);
      released = (sda === 1'b1);
      i2c_stop();
      model_ptr = addr + 16'(n);
   endtask

   task automatic test_reset();
      wait_clk(4);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (wr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_valid: got %b expected 0", wr_valid); end
      checks++; if (wr_addr !== 16'd0) begin errors++; $display("[TB] FAIL reset_wr_addr: got %h expected 0000", wr_addr); end
      checks++; if (wr_data !== 8'd0) begin errors++; $display("[TB] FAIL reset_wr_data: got %h expected 00", wr_data); end
      checks++; if (host_rdata !== 8'd0) begin errors++; $display("[TB] FAIL reset_host_rdata: got %h expected 00", host_rdata); end
      checks++; if (sda !== 1'b1) begin errors++; $display("[TB] FAIL reset_sda: got %b expected 1", sda); end
      rst = 1'b0;
      wait_clk(4);
      for (int i = 0; i < 256; i++) begin
         model_mem[i] = 8'($urandom);
         host_write(16'(i), model_mem[i]);
      end
   endtask

   task automatic test_write();
      logic [7:0] d [8];
      logic [7:0] r;
      bit all_ack, busy_mid;
      int base;
      d = '{default: 8'h00};
      d[0] = 8'hAB; d[1] = 8'hCD;
      base = wr_cnt;
      i2c_write_txn(16'h0010, d, 2, all_ack, busy_mid);
      checks++; if (all_ack !== 1'b1) begin errors++; $display("[TB] FAIL write_acks: got %b expected 1", all_ack); end
      checks++; if (busy_mid !== 1'b1) begin errors++; $display("[TB] FAIL write_busy_mid: got %b expected 1", busy_mid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL write_busy_after_stop: got %b expected 0", busy); end
      checks++; if (wr_cnt - base != 2) begin errors++; $display("[TB] FAIL write_pulses: got %0d expected 2", wr_cnt - base); end
      checks++; if (wr_log[base] !== 24'h0010AB) begin errors++; $display("[TB] FAIL write_evt0: got %h expected 0010ab", wr_log[base]); end
      checks++; if (wr_log[base + 1] !== 24'h0011CD) begin errors++; $display("[TB] FAIL write_evt1: got %h expected 0011cd", wr_log[base + 1]); end
      host_read(16'h0010, r);
      checks++; if (r !== 8'hAB) begin errors++; $display("[TB] FAIL write_mem10: got %h expected ab", r); end
      host_read(16'h0011, r);
      checks++; if (r !== 8'hCD) begin errors++; $display("[TB] FAIL write_mem11: got %h expected cd", r); end
   endtask

   task automatic test_random_read();
      logic [7:0] rd [8];
      logic [7:0] b;
      logic [7:0] exp_b;
      bit all_ack, released, ack;
      host_write(16'h0020, 8'h5A); model_mem[8'h20] = 8'h5A;
      host_write(16'h0021, 8'hA5); model_mem[8'h21] = 8'hA5;
      i2c_read_txn(16'h0020, 2, rd, all_ack, released);
      checks++; if (all_ack !== 1'b1) begin errors++; $display("[TB] FAIL rdrand_acks: got %b expected 1", all_ack); end
      checks++; if (rd[0] !== 8'h5A) begin errors++; $display("[TB] FAIL rdrand_byte0: got %h expected 5a", rd[0]); end
      checks++; if (rd[1] !== 8'hA5) begin errors++; $display("[TB] FAIL rdrand_byte1: got %h expected a5", rd[1]); end
      checks++; if (released !== 1'b1) begin errors++; $display("[TB] FAIL rdrand_release: got %b expected 1", released); end
      // A current-address read shows where the pointer was left
      exp_b = model_mem[model_ptr[7:0]];
      i2c_start();
      send_byte(8'hA1, 1'b0, 16'd0, 8'd0, ack);
      recv_byte(1'b1, b);
      i2c_stop();
      model_ptr = model_ptr + 16'd1;
      checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL rdcur_ack: got %b expected 1", ack); end
      checks++; if (b !== exp_b) begin errors++; $display("[TB] FAIL rdcur_ptr22: got %h expected %h", b, exp_b); end
   endtask

   task automatic test_mismatch();
      bit ack0, ack;
      int low_base, wr_base;
      logic [7:0] r;
      low_base = tgt_low_cnt;
      wr_base = wr_cnt;
      i2c_start();
      send_byte(8'hA2, 1'b0, 16'd0, 8'd0, ack0);
      send_byte(8'h00, 1'b0, 16'd0, 8'd0, ack);
      send_byte(8'h10, 1'b0, 16'd0, 8'd0, ack);
      send_byte(8'h99, 1'b0, 16'd0, 8'd0, ack);
      i2c_stop();
      checks++; if (ack0 !== 1'b0) begin errors++; $display("[TB] FAIL mismatch_ack: got %b expected 0", ack0); end
      checks++; if (tgt_low_cnt != low_base) begin errors++; $display("[TB] FAIL mismatch_sda_low: got %0d expected %0d", tgt_low_cnt, low_base); end
      checks++; if (wr_cnt != wr_base) begin errors++; $display("[TB] FAIL mismatch_wr_valid: got %0d expected %0d", wr_cnt, wr_base); end
      host_read(16'h0010, r);
      checks++; if (r !== model_mem[8'h10]) begin errors++; $display("[TB] FAIL mismatch_mem10: got %h expected %h", r, model_mem[8'h10]); end
      // Moving the device address makes the same address byte acknowledged
      dev_addr_in = 7'h51; dev_addr_wr = 1'b1;
      wait_clk(1);
      dev_addr_wr = 1'b0;
      i2c_start();
      send_byte(8'hA2, 1'b0, 16'd0, 8'd0, ack);
      i2c_stop();
      checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL devaddr_change_ack: got %b expected 1", ack); end
      dev_addr_in = 7'h50; dev_addr_wr = 1'b1;
      wait_clk(1);
      dev_addr_wr = 1'b0;
   endtask

   task automatic test_wrap();
      logic [7:0] d [8];
      logic [7:0] r;
      bit all_ack, busy_mid;
      int base;
      d = '{default: 8'h00};
      d[0] = 8'h11; d[1] = 8'h22;
      base = wr_cnt;
      i2c_write_txn(16'h00FF, d, 2, all_ack, busy_mid);
      checks++; if (all_ack !== 1'b1) begin errors++; $display("[TB] FAIL wrap_acks: got %b expected 1", all_ack); end
      checks++; if (wr_log[base] !== 24'h00FF11) begin errors++; $display("[TB] FAIL wrap_evt0: got %h expected 00ff11", wr_log[base]); end
      checks++; if (wr_log[base + 1] !== 24'h010022) begin errors++; $display("[TB] FAIL wrap_evt1: got %h expected 010022", wr_log[base + 1]); end
      host_read(16'h00FF, r);
      checks++; if (r !== 8'h11) begin errors++; $display("[TB] FAIL wrap_memff: got %h expected 11", r); end
      host_read(16'h0000, r);
      checks++; if (r !== 8'h22) begin errors++; $display("[TB] FAIL wrap_mem00: got %h expected 22", r); end
   endtask

   task automatic test_collision();
      bit ack, all_ack;
      logic [7:0] r;
      i2c_start();
      send_byte(8'hA0, 1'b0, 16'd0, 8'd0, ack); all_ack = ack;
      send_byte(8'h00, 1'b0, 16'd0, 8'd0, ack); all_ack &= ack;
      send_byte(8'h30, 1'b0, 16'd0, 8'd0, ack); all_ack &= ack;
      send_byte(8'h77, 1'b1, 16'h0030, 8'hEE, ack); all_ack &= ack;
      i2c_stop();
      model_mem[8'h30] = 8'h77;
      model_ptr = 16'h0031;
      checks++; if (all_ack !== 1'b1) begin errors++; $display("[TB] FAIL collision_acks: got %b expected 1", all_ack); end
      host_read(16'h0030, r);
      checks++; if (r !== 8'h77) begin errors++; $display("[TB] FAIL collision_mem30: got %h expected 77", r); end
   endtask

   task automatic test_reset_mid_read();
      bit ack, all_ack, busy_mid, released;
      logic [7:0] d [8];
      logic [7:0] rd [8];
      host_write(16'h0040, 8'h00); model_mem[8'h40] = 8'h00;
      i2c_start();
      send_byte(8'hA0, 1'b0, 16'd0, 8'd0, ack);
      send_byte(8'h00, 1'b0, 16'd0, 8'd0, ack);
      send_byte(8'h40, 1'b0, 16'd0, 8'd0, ack);
      i2c_start();
      send_byte(8'hA1, 1'b0, 16'd0, 8'd0, ack);
      m_oe = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_clk(Q); scl = 1'b1; wait_clk(2 * Q); scl = 1'b0;
      end
      wait_clk(Q);
      checks++; if (sda !== 1'b0) begin errors++; $display("[TB] FAIL midrd_bit3_driven: got %b expected 0", sda); end
      rst = 1'b1;
      wait_clk(1);
      rst = 1'b0;
      checks++; if (sda !== 1'b1) begin errors++; $display("[TB] FAIL midrd_sda_release: got %b expected 1", sda); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrd_busy: got %b expected 0", busy); end
      model_ptr = 16'd0;
      i2c_stop();
      d = '{default: 8'h00};
      d[0] = 8'h3C;
      i2c_write_txn(16'h0050, d, 1, all_ack, busy_mid);
      checks++; if (all_ack !== 1'b1) begin errors++; $display("[TB] FAIL midrd_next_wr_acks: got %b expected 1", all_ack); end
      i2c_read_txn(16'h0050, 1, rd, all_ack, released);
      checks++; if (rd[0] !== 8'h3C) begin errors++; $display("[TB] FAIL midrd_next_rd: got %h expected 3c", rd[0]); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d [8];
      logic [7:0] rd [8];
      logic [15:0] addr;
      logic [15:0] ea;
      bit all_ack, busy_mid, released;
      int n, base;
      for (int it = 0; it < 4; it++) begin
         addr = (it == 0) ? 16'hFFFD : 16'($urandom);
         n = $urandom_range(1, 6);
         d = '{default: 8'h00};
         for (int i = 0; i < n; i++) d[i] = 8'($urandom);
         base = wr_cnt;
         i2c_write_txn(addr, d, n, all_ack, busy_mid);
         checks++; if (all_ack !== 1'b1) begin errors++; $display("[TB] FAIL b2b_wr_acks[%0d]: got %b expected 1", it, all_ack); end
         checks++; if (wr_cnt - base != n) begin errors++; $display("[TB] FAIL b2b_pulses[%0d]: got %0d expected %0d", it, wr_cnt - base, n); end
         for (int i = 0; i < n; i++) begin
            ea = addr + 16'(i);
            checks++;
            if (wr_log[base + i] !== {ea, d[i]}) begin
               errors++;
               $display("[TB] FAIL b2b_evt[%0d.%0d]: got %h expected %h", it, i, wr_log[base + i], {ea, d[i]});
            end
         end
         i2c_read_txn(addr, n, rd, all_ack, released);
         checks++; if (all_ack !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rd_acks[%0d]: got %b expected 1", it, all_ack); end
         for (int i = 0; i < n; i++) begin
            ea = addr + 16'(i);
            checks++;
            if (rd[i] !== model_mem[ea[7:0]]) begin
               errors++;
               $display("[TB] FAIL b2b_rd[%0d.%0d]: got %h expected %h", it, i, rd[i], model_mem[ea[7:0]]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_random_read();
      test_mismatch();
      test_wrap();
      test_collision();
      test_reset_mid_read();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_target_responder.md
Name: i2c_target_responder

Overview:
- I2C target (slave) that answers the transactions issued by the team's I2C master handler: 7-bit device address, 16-bit big-endian register address, multi-byte write and read with pointer auto-increment.
- Backed by an internal byte memory with a host-side port for preload/readback, plus a write-notification strobe.
- Used as an on-board EEPROM stand-in and as a loopback target for master bring-up.

Parameters:
MEM_DEPTH, 256, memory bytes; power of 2; pointer index = ptr mod MEM_DEPTH.
DEV_ADDR_RST, 7'h50, device address loaded into dev_addr_reg at reset.

Ports:
clk  input  1  system clock; must be at least 16x SCL frequency.
rst  input  1  synchronous, active-high reset.
i2c_scl  input  1  bus clock (target never stretches).
i2c_sda  inout  1  open drain: driven 0 when sda_oe=1, else Z.
dev_addr_wr  input  1  load dev_addr_in into dev_addr_reg.
dev_addr_in  input  7  new device address.
host_we  input  1  host memory write strobe.
host_addr  input  16  host memory address, mod MEM_DEPTH.
host_wdata  input  8  host write data.
host_rdata  output  8  mem[host_addr], registered, 1-cycle latency.
wr_valid  output  1  1-cycle pulse per I2C data byte written.
wr_addr  output  16  full pointer value of that byte.
wr_data  output  8  byte written.
busy  output  1  high from START to STOP.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high.
- Reset values: sda_oe=0 (SDA released), busy=0, wr_valid=0, wr_addr=0, wr_data=0, host_rdata=0, ptr=0, dev_addr_reg=DEV_ADDR_RST, state=S_IDLE. Memory contents are not reset.
- Reset mid-transfer: SDA is released in the cycle after rst is sampled. The state machine returns to S_IDLE and waits for the next START.
- Input conditioning: SCL and SDA each pass through 2-FF synchronisers, then a previous-value register.
  - scl_rise / scl_fall: edges of the synchronised SCL.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Detection latency is 3 clk cycles.
- Sampling and driving rules:
  - Bits are sampled on scl_rise, MSB first.
  - sda_oe changes only on scl_fall, so SDA is stable while SCL is high.
- START in any state (including repeated START): clear the bit counter, release SDA, go to S_DEV_ADDR, set busy=1.
- STOP in any state: release SDA, go to S_IDLE, set busy=0. ptr is retained.
- State machine:
  - S_IDLE: ignore everything except START.
  - S_DEV_ADDR: shift 8 bits.
    - Upper 7 bits != dev_addr_reg: go to S_IGNORE and never drive SDA.
    - Match with R/W=0: go to S_ACK_DEV, then S_REG_HI.
    - Match with R/W=1: go to S_ACK_DEV, then S_RD_LOAD.
  - S_ACK_DEV / S_ACK_HI / S_ACK_LO / S_ACK_WR:
    - Assert sda_oe on the scl_fall ending bit 8.
    - Release on the next scl_fall.
  - S_REG_HI: byte goes to ptr[15:8]. Then ACK.
  - S_REG_LO: byte goes to ptr[7:0]. Then ACK, then S_WR_DATA.
  - S_WR_DATA: on the 8th bit:
    - Write mem[ptr mod MEM_DEPTH].
    - Pulse wr_valid with wr_addr=ptr and wr_data=byte.
    - ptr increments by 1, wrapping 16'hFFFF -> 0.
    - ACK, then stay in S_WR_DATA.
  - S_RD_LOAD: latch mem[ptr mod MEM_DEPTH] into the shift register. Go to S_RD_DATA.
  - S_RD_DATA:
    - Drive the 8 bits MSB first: sda_oe = ~bit, updated on scl_fall.
    - After bit 8, release SDA, ptr increments, go to S_RD_ACK.
  - S_RD_ACK: sample the master's ACK on scl_rise.
    - SDA=0 (ACK): go to S_RD_LOAD.
    - SDA=1 (NACK): go to S_IGNORE.
  - S_IGNORE: SDA released; wait for START or STOP.
- Collision: if host_we and an I2C byte write target the same memory index in the same cycle, the I2C write wins.
- host_rdata reflects any write by the following cycle.
- dev_addr_wr takes effect immediately, including for a transfer already in progress.

Decomposition:
- Shared package i2c_pkg:
  - target state encoding (4-bit localparams);
  - I2C command codes 8'h04/05/06, shared with the master handler;
  - DEV_ADDR default 7'h50.
- Sub-module i2c_bus_monitor:
  - synchronisers and edge detectors;
  - outputs scl_rise, scl_fall, start_det, stop_det, sda_s.
- Top holds the FSM, pointer, memory and host port.

Test Plan:
- Write: START, 0xA0, 0x00, 0x10, 0xAB, 0xCD, STOP -> target ACKs all 5 bytes; mem[0x10]=0xAB, mem[0x11]=0xCD; wr_valid pulses twice with wr_addr 0x0010 then 0x0011; busy falls after STOP.
- Random read: host preloads mem[0x20]=0x5A, mem[0x21]=0xA5; START, 0xA0, 0x00, 0x20, Sr, 0xA1, read with ACK then NACK, STOP -> bytes 0x5A, 0xA5 returned; SDA released after the NACK; ptr=0x0022.
- Address mismatch: START, 0xA2, then 3 bytes, STOP -> SDA never driven low; no wr_valid; memory unchanged.
- Wrap: MEM_DEPTH=256, write 0x00FF followed by 0x11, 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22; wr_addr 0x00FF then 0x0100.
- Reset mid-read: assert rst while driving bit 3 of 0x00 -> SDA released the next cycle; busy=0; the next transaction completes normally.
- Collision: host_we to index 0x30 in the same cycle as the I2C write of 0x77 to 0x0030 -> mem[0x30]=0x77.
